// File: rtl/conv_layer_input_ctrl.sv
// Sequencing controller for the conv layer's KERNEL_SIZE-row input line buffer.
// Walks one feature map per start: preload, then alternating sweep/bias and single-row refill.
module conv_layer_input_ctrl #(
   parameter int IMAGE_SIZE       = 8,
   parameter int KERNEL_SIZE      = 3,
   parameter int BUFFER_COL_WIDTH = 4,
   parameter int BUFFER_ROW_WIDTH = 2,
   parameter int OUT_SIZE         = IMAGE_SIZE - KERNEL_SIZE + 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        in_valid,
   output logic                        data_req,
   output logic [2:0]                  current_state,
   output logic [BUFFER_COL_WIDTH-1:0] col_index,
   output logic [BUFFER_ROW_WIDTH-1:0] row_index,
   output logic [BUFFER_ROW_WIDTH-1:0] preload_cycle,
   output logic [2:0]                  out_row,
   output logic                        row_done,
   output logic                        map_done
);

   typedef enum logic [2:0] {
      STATE_INIT    = 3'd0,
      STATE_PRELOAD = 3'd1,
      STATE_SHIFT   = 3'd2,
      STATE_BIAS    = 3'd3,
      STATE_LOAD    = 3'd4,
      STATE_IDLE    = 3'd5
   } state_t;

   localparam logic [BUFFER_COL_WIDTH-1:0] COL_LAST = BUFFER_COL_WIDTH'(IMAGE_SIZE - 1);
   localparam logic [BUFFER_COL_WIDTH-1:0] COL_END  = BUFFER_COL_WIDTH'(IMAGE_SIZE);
   localparam logic [BUFFER_ROW_WIDTH-1:0] ROW_LAST = BUFFER_ROW_WIDTH'(KERNEL_SIZE - 1);
   localparam logic [BUFFER_ROW_WIDTH-1:0] ROW_K    = BUFFER_ROW_WIDTH'(KERNEL_SIZE);
   localparam logic [2:0]                  OUT_LAST = 3'(OUT_SIZE - 1);

   state_t                      state_q, state_d;
   logic [BUFFER_COL_WIDTH-1:0] col_q, col_d;
   logic [BUFFER_ROW_WIDTH-1:0] row_q, row_d;
   logic [BUFFER_ROW_WIDTH-1:0] pre_q, pre_d;
   logic [2:0]                  orow_q, orow_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= STATE_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         pre_q   <= '0;
         orow_q  <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         pre_q   <= pre_d;
         orow_q  <= orow_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      pre_d    = pre_q;
      orow_d   = orow_q;
      data_req = 1'b0;
      case (state_q)
         STATE_IDLE: begin
            if (start) begin
               state_d = STATE_INIT;
               col_d   = '0;
               row_d   = '0;
               pre_d   = '0;
               orow_d  = '0;
            end
         end
         STATE_INIT: begin
            state_d = STATE_PRELOAD;
            col_d   = '0;
            row_d   = '0;
            pre_d   = '0;
            orow_d  = '0;
         end
         STATE_PRELOAD: begin
            // col parked at IMAGE_SIZE is the buffer's row-shift slot between preload rows
            if (col_q == COL_END) begin
               col_d = '0;
               pre_d = pre_q + 1'b1;
            end else begin
               data_req = 1'b1;
               if (in_valid) begin
                  if (col_q == COL_LAST && pre_q == ROW_LAST) begin
                     state_d = STATE_SHIFT;
                     col_d   = '0;
                     pre_d   = ROW_K;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end
            end
         end
         STATE_SHIFT: begin
            if (col_q == COL_LAST) begin
               col_d = '0;
               if (row_q == ROW_LAST) begin
                  row_d   = '0;
                  state_d = STATE_BIAS;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         STATE_BIAS: begin
            col_d = '0;
            row_d = '0;
            if (orow_q == OUT_LAST) begin
               orow_d  = '0;
               state_d = STATE_IDLE;
            end else begin
               orow_d  = orow_q + 1'b1;
               state_d = STATE_LOAD;
            end
         end
         STATE_LOAD: begin
            data_req = 1'b1;
            if (in_valid) begin
               if (col_q == COL_LAST) begin
                  col_d   = '0;
                  state_d = STATE_SHIFT;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         default: state_d = STATE_IDLE;
      endcase
   end

   // A stalled request cycle must look idle to the buffer so nothing is written or shifted
   assign current_state = (data_req && !in_valid) ? STATE_IDLE : state_q;
   assign col_index     = col_q;
   assign row_index     = row_q;
   assign preload_cycle = pre_q;
   assign out_row       = orow_q;
   assign row_done      = (state_q == STATE_BIAS);
   assign map_done      = (state_q == STATE_BIAS) && (orow_q == OUT_LAST);

endmodule

// File: tb/tb_conv_layer_input_ctrl.sv
// Bench for conv_layer_input_ctrl: per-cycle compare against a step-schedule model of one map,
// plus literal latency / pixel-count / stall expectations.
module tb_conv_layer_input_ctrl;

   localparam int IMG  = 8;
   localparam int K    = 3;
   localparam int OUTS = IMG - K + 1;

   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
   logic       data_req, row_done, map_done;
   logic [2:0] current_state, out_row;
   logic [3:0] col_index;
   logic [1:0] row_index, preload_cycle;

   conv_layer_input_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .data_req(data_req), .current_state(current_state), .col_index(col_index),
      .row_index(row_index), .preload_cycle(preload_cycle), .out_row(out_row),
      .row_done(row_done), .map_done(map_done)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // One entry per cycle of an unstalled map; acc steps wait for in_valid.
   typedef struct {
      int st; int col; int row; int pre; int orow; bit acc; bit rd; bit md;
   } step_t;
   step_t sched[$];

   function automatic void add(int st, int col, int row, int pre, int orow, bit acc, bit rd, bit md);
      step_t e;
      e.st = st; e.col = col; e.row = row; e.pre = pre; e.orow = orow;
      e.acc = acc; e.rd = rd; e.md = md;
      sched.push_back(e);
   endfunction

   function automatic void build();
      sched.delete();
      add(0, 0, 0, -1, 0, 0, 0, 0);
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < IMG; c++) add(1, c, 0, r, 0, 1, 0, 0);
         if (r < K - 1) add(1, IMG, 0, r, 0, 0, 0, 0);
      end
      for (int o = 0; o < OUTS; o++) begin
         for (int k = 0; k < K * IMG; k++) add(2, k % IMG, k / IMG, K, o, 0, 0, 0);
         add(3, 0, 0, K, o, 0, 1, o == OUTS - 1);
         if (o < OUTS - 1)
            for (int c = 0; c < IMG; c++) add(4, c, 0, K, o + 1, 1, 0, 0);
      end
   endfunction

   bit    in_map = 0;
   int    idx = 0, pre_idle = 0;
   step_t s;
   int    e_st, e_col, e_row, e_pre, e_orow, e_dr, e_rd, e_md;
   bit    stl;

   always @(negedge clk) begin
      stl = 1'b0;
      if (!rst_n) begin
         in_map = 0; pre_idle = 0;
         e_st = 5; e_col = 0; e_row = 0; e_pre = 0; e_orow = 0; e_dr = 0; e_rd = 0; e_md = 0;
      end else if (!in_map) begin
         e_st = 5; e_col = 0; e_row = 0; e_pre = pre_idle; e_orow = 0; e_dr = 0; e_rd = 0; e_md = 0;
      end else begin
         s    = sched[idx];
         stl  = s.acc && !in_valid;
         e_st = stl ? 5 : s.st;
         e_col = s.col; e_row = s.row; e_pre = s.pre; e_orow = s.orow;
         e_dr = s.acc; e_rd = s.rd; e_md = s.md;
      end
      chk("current_state", current_state, e_st);
      chk("col_index", col_index, e_col);
      chk("row_index", row_index, e_row);
      if (e_pre >= 0) chk("preload_cycle", preload_cycle, e_pre);
      chk("out_row", out_row, e_orow);
      chk("data_req", data_req, e_dr);
      chk("row_done", row_done, e_rd);
      chk("map_done", map_done, e_md);
      if (rst_n) begin
         if (!in_map) begin
            if (start) begin in_map = 1; idx = 0; end
         end else if (!stl) begin
            idx++;
            if (idx == sched.size()) begin in_map = 0; pre_idle = K; end
         end
      end
   end

   // Independent observation of the DUT for literal end-of-map checks
   bit tracking = 0;
   int lat = 0, acc = 0, rd = 0, first_shift = 0;
   int last_lat = 0, last_acc = 0, last_rd = 0, md_count = 0, stall_viol = 0;

   always @(negedge clk) begin
      if (!rst_n) tracking = 0;
      else if (tracking) begin
         lat++;
         if (data_req && in_valid) acc++;
         if (row_done) rd++;
         if (current_state == 3'd2 && first_shift == 0) first_shift = lat;
         if (map_done) begin last_lat = lat; last_acc = acc; last_rd = rd; tracking = 0; end
      end else if (start && current_state == 3'd5 && !data_req) begin
         tracking = 1; lat = 1; acc = 0; rd = 0; first_shift = 0;
      end
      if (rst_n && map_done) md_count++;
      if (rst_n && data_req && !in_valid && (current_state == 3'd1 || current_state == 3'd4))
         stall_viol++;
   end

   task automatic tick();
      @(posedge clk); #2;
   endtask

   // mode 0: continuous valid + start pulse in SHIFT; 1: 4-cycle stall at first LOAD col 0; 2: random gaps
   task automatic run_map(input int mode);
      int  md0;
      bit  stalled, pulsed;
      md0 = md_count; stalled = 0; pulsed = 0;
      start = 1'b1;
      in_valid = (mode == 2) ? ($urandom_range(0, 99) >= 30) : 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 3000 && md_count == md0; n++) begin
         if (mode == 2) in_valid = ($urandom_range(0, 99) >= 30);
         else if (mode == 1 && !stalled && current_state == 3'd4 && col_index == 4'd0) begin
            stalled = 1; in_valid = 1'b0;
            for (int j = 0; j < 4; j++) begin
               @(negedge clk);
               chk("stall_state", current_state, 5);
               chk("stall_req", data_req, 1);
               chk("stall_col", col_index, 0);
               @(posedge clk); #2;
            end
            in_valid = 1'b1;
            @(negedge clk);
            chk("resume_state", current_state, 4);
            chk("resume_col", col_index, 0);
         end else if (mode == 0 && !pulsed && current_state == 3'd2) begin
            pulsed = 1; start = 1'b1;
         end
         tick();
         start = 1'b0;
      end
      chk("map_timeout", int'(md_count != md0), 1);
      repeat (3) tick();
      chk("map_done_once", md_count - md0, 1);
      chk("accepted_pixels", last_acc, 64);
      chk("row_done_count", last_rd, OUTS);
      if (mode == 0) begin
         chk("latency", last_lat, 218);
         chk("first_shift_cycle", first_shift, 29);
      end
      if (mode == 1) chk("latency_stalled", last_lat, 222);
   endtask

   initial begin
      build();
      chk("schedule_len", sched.size(), 217);
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // reset in the middle of preload
      begin
         bit hit;
         hit = 0;
         start = 1'b1; in_valid = 1'b1;
         tick();
         start = 1'b0;
         for (int n = 0; n < 40 && !hit; n++) begin
            if (current_state == 3'd1 && col_index == 4'd5) hit = 1;
            else tick();
         end
         chk("reach_preload_col5", int'(hit), 1);
         rst_n = 1'b0;
         #1;
         chk("rst_state", current_state, 5);
         chk("rst_col", col_index, 0);
         chk("rst_pre", preload_cycle, 0);
         chk("rst_req", data_req, 0);
         tick();
         rst_n = 1'b1;
         in_valid = 1'b0;
         tick();
      end

      run_map(0);
      run_map(1);
      for (int m = 0; m < 2; m++) run_map(2);
      chk("stall_shows_idle", stall_viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
